// File: rtl/core_regfile_mp.sv
// core_regfile_mp: parametrised multi-read-port register file.
// - NUM_RD registered read ports (1-cycle latency) and one write port.
// - Write-first bypass from the write port to matching read ports.
// - Optional hardwired zero register (ZERO_REG=1).
// - Post-reset clear sequencer zeroes every entry; busy_o is high while it runs.
// - Optional even-parity protection per entry, enabled by defining the macro
//   CORE_REGFILE_PARITY_EN. The default build has no parity storage, and
//   par_err_o is tied to zero.
module core_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD-1:0]        rd_re_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     wr_we_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     busy_o,
  output logic [NUM_RD-1:0]        par_err_o
);

`ifdef CORE_REGFILE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int ENTRY_W = DATA_W + PAR_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDR_W:0]            r_clr_cnt;
  logic [ENTRY_W-1:0]         r_mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0]   r_rd_data;
  logic [NUM_RD*DATA_W-1:0]   w_rd_nxt;
  logic [NUM_RD-1:0]          r_par_err;
  logic [NUM_RD-1:0]          w_err_nxt;
  logic                       w_wr_zero;
  logic                       w_mem_we;
  logic [ADDR_W-1:0]          w_mem_addr;
  logic [ENTRY_W-1:0]         w_mem_wdata;
  logic [ADDR_W-1:0]          w_rd_addr;
  logic [ENTRY_W-1:0]         w_rd_ent;

  // A write aimed at the hardwired zero register is dropped, and it never bypasses.
  assign w_wr_zero = (ZERO_REG != 0) && (wr_addr_i == '0);

  // Next-state logic: leave CLEAR after the cycle that writes the last entry.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_cnt == CLR_LAST) begin
      w_state_nxt = ST_READY;
    end
  end

  // State register and clear counter. The counter is one bit wider than the
  // address, so it stops at DEPTH without wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + (ADDR_W+1)'(1);
      end
    end
  end

  // Storage write mux: the clear sequencer owns the port in CLEAR, and
  // writeback owns it in READY.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = wr_addr_i;
    w_mem_wdata = '0;
    if (r_state == ST_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_cnt[ADDR_W-1:0];
    end else if (wr_we_i && !w_wr_zero) begin
      w_mem_we                  = 1'b1;
      w_mem_wdata[DATA_W-1:0]   = wr_data_i;
`ifdef CORE_REGFILE_PARITY_EN
      w_mem_wdata[DATA_W]       = ^wr_data_i;
`endif
    end
  end

  // Storage array update.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset; the clear sequencer zeroes it after reset.
    if (rst_n_i && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Per-port read selection: bypass first, then the zero register, then storage.
  always_comb begin
    w_rd_nxt  = r_rd_data;
    w_err_nxt = '0;
    w_rd_addr = '0;
    w_rd_ent  = '0;
    if (r_state == ST_READY) begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_re_i[k]) begin
          w_rd_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
          w_rd_ent  = r_mem[w_rd_addr];
          if (wr_we_i && !w_wr_zero && wr_addr_i == w_rd_addr) begin
            w_rd_nxt[k*DATA_W +: DATA_W] = wr_data_i;
          end else if (ZERO_REG != 0 && w_rd_addr == '0) begin
            w_rd_nxt[k*DATA_W +: DATA_W] = '0;
          end else begin
            w_rd_nxt[k*DATA_W +: DATA_W] = w_rd_ent[DATA_W-1:0];
`ifdef CORE_REGFILE_PARITY_EN
            w_err_nxt[k] = (^w_rd_ent[DATA_W-1:0]) != w_rd_ent[DATA_W];
`endif
          end
        end
      end
    end
  end

  // Registered read data and parity-error pulses. The error pulse lines up with the data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rd_data <= '0;
      r_par_err <= '0;
    end else begin
      r_rd_data <= w_rd_nxt;
      r_par_err <= w_err_nxt;
    end
  end

  assign rd_data_o = r_rd_data;
  assign par_err_o = r_par_err;
  assign busy_o    = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_core_regfile_mp.sv
// Testbench for core_regfile_mp with the default parameters
// (32-bit data, 32 entries, 2 read ports, hardwired zero register).
// Covers clear timing, reads, bypass, the zero register, hold and reset
// during CLEAR. The parity check runs when CORE_REGFILE_PARITY_EN is defined.
module tb_core_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk_i;
  logic                     rst_n_i;
  logic [NUM_RD-1:0]        rd_re_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic                     wr_we_i;
  logic [ADDR_W-1:0]        wr_addr_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic                     busy_o;
  logic [NUM_RD-1:0]        par_err_o;

  int n_checks = 0;
  int n_errors = 0;

  core_regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rd_re_i(rd_re_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .wr_we_i(wr_we_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .busy_o(busy_o), .par_err_o(par_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Stop the run if it ever hangs.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then wait 1 time unit so outputs can be sampled.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    rd_re_i   = re;
    rd_addr_i = {a1, a0};
    wr_we_i   = we;
    wr_addr_i = wa;
    wr_data_i = wd;
  endtask

  // Count the edges until busy_o drops. The wait is bounded to 100 edges.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (busy_o === 1'b1 && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  int cyc;

  initial begin
    // Each vector drives its inputs for one edge. The expected values show
    // rd_data_o just after that edge.
    vecs[0]  = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0,          32'h0};
    vecs[1]  = '{2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2]  = '{2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3]  = '{2'b11, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4]  = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[5]  = '{2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,         32'h0,          32'h0};
    vecs[6]  = '{2'b11, 5'd0, 5'd3, 1'b1, 5'd0, 32'hAAAA_AAAA, 32'h0,          32'h1234_5678};
    vecs[7]  = '{2'b11, 5'd5, 5'd5, 1'b1, 5'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[8]  = '{2'b00, 5'd5, 5'd5, 1'b1, 5'd5, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[9]  = '{2'b00, 5'd5, 5'd5, 1'b1, 5'd5, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[10] = '{2'b00, 5'd5, 5'd5, 1'b1, 5'd5, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[11] = '{2'b11, 5'd5, 5'd7, 1'b0, 5'd0, 32'h0,         32'h0,          32'hDEAD_BEEF};
    vecs[12] = '{2'b10, 5'd7, 5'd3, 1'b1, 5'd9, 32'h0F0F_0F0F, 32'h0,          32'h1234_5678};
    vecs[13] = '{2'b11, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0,         32'h0F0F_0F0F, 32'h0F0F_0F0F};

    drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    rst_n_i = 1'b0;
    step();
    step();
    check("reset_busy", 64'(busy_o), 64'd1);
    check("reset_rd_data", 64'(rd_data_o), 64'd0);
    check("reset_par_err", 64'(par_err_o), 64'd0);

    // Clear duration after reset is released.
    rst_n_i = 1'b1;
    wait_ready(cyc);
    check("clear_cycles", 64'(cyc), 64'd32);

    // Read every entry after the clear.
    for (int i = 0; i < 32; i++) begin
      drive(2'b11, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
      step();
      check($sformatf("cleared_r%0d", i), 64'(rd_data_o), 64'd0);
    end

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].re, vecs[i].a0, vecs[i].a1, vecs[i].we, vecs[i].wa, vecs[i].wd);
      step();
      check($sformatf("vec%0d_port0", i), 64'(rd_data_o[31:0]), 64'(vecs[i].exp0));
      check($sformatf("vec%0d_port1", i), 64'(rd_data_o[63:32]), 64'(vecs[i].exp1));
      check($sformatf("vec%0d_par_err", i), 64'(par_err_o), 64'd0);
    end

`ifdef CORE_REGFILE_PARITY_EN
    // Flip a stored data bit in r9 through the backdoor, then read r9 on port 1.
    drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    dut.r_mem[9][0] = ~dut.r_mem[9][0];
    drive(2'b10, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0);
    step();
    check("par_rd_data", 64'(rd_data_o[63:32]), 64'h0F0F_0F0E);
    check("par_err_pulse", 64'(par_err_o), 64'd2);
    drive(2'b00, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0);
    step();
    check("par_err_one_cycle", 64'(par_err_o), 64'd0);
    // A bypassed read of the corrupted entry never flags an error.
    drive(2'b10, 5'd0, 5'd9, 1'b1, 5'd9, 32'h0000_0001);
    step();
    check("par_bypass_data", 64'(rd_data_o[63:32]), 64'h1);
    check("par_bypass_no_err", 64'(par_err_o), 64'd0);
`else
    drive(2'b10, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0);
    step();
    check("nopar_rd_data", 64'(rd_data_o[63:32]), 64'h0F0F_0F0F);
    check("nopar_err_zero", 64'(par_err_o), 64'd0);
`endif

    // Reset during normal operation returns the outputs to their reset values.
    drive(2'b11, 5'd7, 5'd3, 1'b1, 5'd7, 32'h5555_5555);
    rst_n_i = 1'b0;
    step();
    check("midop_rst_busy", 64'(busy_o), 64'd1);
    check("midop_rst_rd_data", 64'(rd_data_o), 64'd0);
    drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("midclear_busy", 64'(busy_o), 64'd1);
    // The counter is at 10 here. Reset again and confirm that a full clear follows.
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    wait_ready(cyc);
    check("reclear_cycles", 64'(cyc), 64'd32);

    // Entries written before the reset are zero after the new clear.
    drive(2'b11, 5'd7, 5'd3, 1'b0, 5'd0, 32'h0);
    step();
    check("reclear_r7_r3", 64'(rd_data_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/core_regfile_mp.md
Name: core_regfile_mp

Overview:
- Parametrised multi-read-port integer register file; next generation of the core's 2R1W register file.
- Adds configurable width, depth and read-port count, hardwired zero register, write-to-read bypass, and a post-reset hardware clear sequencer.
- Sits between decode (read ports) and writeback (write port).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports; legal range 1..4.
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero; when 0, entry 0 is an ordinary register.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- rd_re_i  in  NUM_RD  per-port read enable.
- rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  packed registered read data; port k at [k*DATA_W +: DATA_W].
- wr_we_i  in  1  write enable.
- wr_addr_i  in  ADDR_W  write address.
- wr_data_i  in  DATA_W  write data.
- busy_o  out  1  high while the clear sequencer runs.
- par_err_o  out  NUM_RD  per-port parity error pulse (see Optional Feature).

Behaviour:
- Reset: rst_n_i low at a rising edge sets state=CLEAR, clr_cnt=0, rd_data_o=0, busy_o=1, par_err_o=0. Storage is not reset directly.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 (and parity 0) to entry clr_cnt, then increments clr_cnt.
  - After the cycle that writes entry 2**ADDR_W-1, the FSM enters READY; busy_o goes low from that edge.
  - Total CLEAR duration is exactly 2**ADDR_W cycles after reset deasserts.
  - In CLEAR, wr_we_i and rd_re_i are ignored and rd_data_o holds 0.
- READY:
  - Read: if rd_re_i[k] is high at edge N, rd_data_o[k] is valid after edge N (1-cycle latency).
  - If rd_re_i[k] is low, rd_data_o[k] holds its previous value.
  - Write: if wr_we_i is high, the entry is updated at the edge.
  - Bypass (write-first): if wr_we_i is high, rd_re_i[k] is high and wr_addr_i==rd_addr_i[k] in the same cycle, rd_data_o[k] takes wr_data_i.
  - Multiple read ports may share an address; every port returns the same value.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
  - No bypass applies when wr_addr_i==0.
- ZERO_REG=0: entry 0 behaves like any other entry.
- Reset mid-CLEAR or mid-operation: the FSM restarts CLEAR from clr_cnt=0; all outputs return to their reset values.
- Widths: clr_cnt is ADDR_W+1 bits so the terminal count does not wrap. All addresses are unsigned; no out-of-range case exists.

Optional Feature:
- Macro: CORE_REGFILE_PARITY_EN.
- Defined:
  - Each entry stores DATA_W+1 bits; the extra bit is the even parity of the data (XOR reduction), computed on write.
  - On a read of a non-bypassed, non-zero-register entry, recomputed parity is compared with the stored bit.
  - A mismatch pulses par_err_o[k] high for one cycle, aligned with rd_data_o[k].
  - Bypassed reads and address-0 reads under ZERO_REG=1 never flag an error.
- Undefined: no parity storage is built; par_err_o is tied to 0.

Test Plan:
1. Reset low 2 cycles, then high -> busy_o stays 1 for exactly 32 cycles (ADDR_W=5), then 0. A read of every address afterwards returns 0x0000_0000.
2. READY: write 0xDEAD_BEEF to r7, next cycle read r7 on port 0 and r7 on port 1 -> both rd_data_o return 0xDEAD_BEEF one cycle later.
3. Same cycle: write 0x1234_5678 to r3 while port 0 reads r3 (old value 0) -> rd_data_o[0]=0x1234_5678 after the edge. A later read returns 0x1234_5678.
4. ZERO_REG=1: write 0xFFFF_FFFF to r0, then read r0 -> 0. With a same-cycle write to r0 and a read of r0 -> 0.
5. Write r5=0xA5A5_A5A5, hold rd_re_i=0 for 3 cycles while writing r5=0x0 -> rd_data_o is unchanged. Assert reset at clr_cnt=10 during a later CLEAR -> busy_o stays high for a full 32 cycles after release.
6. With CORE_REGFILE_PARITY_EN: force a stored data bit flip in r9 by backdoor, then read r9 on port 1 -> par_err_o[1] pulses for 1 cycle with the data. Without the macro, par_err_o stays 0.
